nexys4ddr_buttons: RTL and testbench

NEXYS4DDR_BUTTONS -- requirements
Module: nexys4ddr_buttons

---
 rtl/nexys4ddr_pkg.sv | 21 ++
 rtl/nexys4ddr_debounce.sv | 65 ++++++
 rtl/nexys4ddr_buttons.sv | 73 +++++++
 tb/tb_nexys4ddr_buttons.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nexys4ddr_pkg.sv
// Shared constants for the Nexys4 DDR button/switch front end:
// button bit positions, input counts and the debounce length helper.
package nexys4ddr_pkg;

  localparam int NUM_BTN    = 5;
  localparam int NUM_SW     = 16;
  localparam int NUM_INPUTS = NUM_BTN + NUM_SW;

  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_D = 4;

  // Stable time in clock cycles; FREQ is expected to be a multiple of 1000.
  function automatic logic [31:0] deb_cycles(input logic [31:0] freq_hz,
                                             input logic [31:0] stable_ms);
    return (freq_hz / 32'd1000) * stable_ms;
  endfunction

endpackage

// File: rtl/nexys4ddr_debounce.sv
// One-bit front end: two-flop synchronizer, stability counter and
// registered rise/fall pulses that coincide with the level update.
module nexys4ddr_debounce
  import nexys4ddr_pkg::*;
#(
  parameter logic [31:0] CYCLES = 32'd1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic        r_sync1;
  logic        r_sync2;
  logic        r_lvl;
  logic        r_rise;
  logic        r_fall;
  logic [31:0] r_cnt;
  logic        w_differs;
  logic        w_done;

  assign w_differs = (r_sync2 != r_lvl);
  assign w_done    = (r_cnt == (CYCLES - 32'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= in;
      r_sync2 <= r_sync1;
    end
  end

  // Any cycle where the synchronized input agrees with the level cancels a pending change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_lvl  <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (!w_differs) begin
        r_cnt <= '0;
      end else if (!w_done) begin
        r_cnt <= r_cnt + 32'd1;
      end else begin
        r_cnt  <= '0;
        r_lvl  <= r_sync2;
        r_rise <= r_sync2;
        r_fall <= ~r_sync2;
      end
    end
  end

  assign level = r_lvl;
  assign rise  = r_rise;
  assign fall  = r_fall;

endmodule

// File: rtl/nexys4ddr_buttons.sv
// Debounced push buttons and slide switches for the Nexys4 DDR board,
// with press/release pulses per button and a single switch-change pulse.
module nexys4ddr_buttons
  import nexys4ddr_pkg::*;
#(
  parameter logic [31:0] FREQ        = 32'hx,
  parameter int unsigned DEBOUNCE_MS = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 BTNC,
  input  logic                 BTNU,
  input  logic                 BTNL,
  input  logic                 BTNR,
  input  logic                 BTND,
  input  logic [NUM_SW-1:0]    SW,
  output logic [NUM_BTN-1:0]   btn,
  output logic [NUM_BTN-1:0]   btn_press,
  output logic [NUM_BTN-1:0]   btn_release,
  output logic [NUM_SW-1:0]    sw,
  output logic                 sw_change
);

  localparam logic [31:0] DEB_CYCLES = deb_cycles(FREQ, 32'(DEBOUNCE_MS));

  logic [NUM_BTN-1:0] w_btn_raw;
  logic [NUM_SW-1:0]  w_sw_rise;
  logic [NUM_SW-1:0]  w_sw_fall;
  logic               r_sw_change;

  always_comb begin
    w_btn_raw        = '0;
    w_btn_raw[BTN_C] = BTNC;
    w_btn_raw[BTN_U] = BTNU;
    w_btn_raw[BTN_L] = BTNL;
    w_btn_raw[BTN_R] = BTNR;
    w_btn_raw[BTN_D] = BTND;
  end

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    nexys4ddr_debounce #(.CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .in    (w_btn_raw[gi]),
      .level (btn[gi]),
      .rise  (btn_press[gi]),
      .fall  (btn_release[gi])
    );
  end

  for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_sw
    nexys4ddr_debounce #(.CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .in    (SW[gi]),
      .level (sw[gi]),
      .rise  (w_sw_rise[gi]),
      .fall  (w_sw_fall[gi])
    );
  end

  // Several switches flipping together still yield one pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_change <= 1'b0;
    end else begin
      r_sw_change <= |(w_sw_rise | w_sw_fall);
    end
  end

  assign sw_change = r_sw_change;

endmodule

// File: tb/tb_nexys4ddr_buttons.sv
// Bench for nexys4ddr_buttons: directed scenarios plus random toggling,
// every cycle compared against a window-based reference model.
module tb_nexys4ddr_buttons;
  import nexys4ddr_pkg::*;

  localparam int DEB = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                BTNC, BTNU, BTNL, BTNR, BTND;
  logic [NUM_SW-1:0]   SW;
  logic [NUM_BTN-1:0]  btn, btn_press, btn_release;
  logic [NUM_SW-1:0]   sw;
  logic                sw_change;

  int testCount = 0;
  int failCount = 0;

  // Reference model: raw history per input, and values seen since the last level flip.
  bit rawHist[NUM_INPUTS][$];
  bit pend[NUM_INPUTS][$];
  bit mLvl[NUM_INPUTS];
  bit mRise[NUM_INPUTS];
  bit mFall[NUM_INPUTS];
  bit mSwChg;
  bit swFlipPrev;

  nexys4ddr_buttons #(.FREQ(32'd4000), .DEBOUNCE_MS(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .BTNC        (BTNC),
    .BTNU        (BTNU),
    .BTNL        (BTNL),
    .BTNR        (BTNR),
    .BTND        (BTND),
    .SW          (SW),
    .btn         (btn),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .sw          (sw),
    .sw_change   (sw_change)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] b, input logic [15:0] s);
    BTNC = b[0];
    BTNU = b[1];
    BTNL = b[2];
    BTNR = b[3];
    BTND = b[4];
    SW   = s;
  endtask

  task automatic modelReset();
    for (int i = 0; i < NUM_INPUTS; i++) begin
      rawHist[i].delete();
      pend[i].delete();
      mLvl[i]  = 1'b0;
      mRise[i] = 1'b0;
      mFall[i] = 1'b0;
    end
    mSwChg     = 1'b0;
    swFlipPrev = 1'b0;
  endtask

  // A level flips once the last DEB delayed samples since the previous flip all disagree with it.
  task automatic modelEdge();
    logic [20:0] r;
    bit anySw;
    bit s;
    bit allDiff;
    int sz;
    r      = {SW, BTND, BTNR, BTNL, BTNU, BTNC};
    anySw  = 1'b0;
    mSwChg = swFlipPrev;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      rawHist[i].push_back(r[i]);
      sz = rawHist[i].size();
      s  = (sz >= 3) ? rawHist[i][sz-3] : 1'b0;
      if (sz > 3) void'(rawHist[i].pop_front());
      pend[i].push_back(s);
      if (pend[i].size() > DEB) void'(pend[i].pop_front());
      mRise[i] = 1'b0;
      mFall[i] = 1'b0;
      if (pend[i].size() == DEB) begin
        allDiff = 1'b1;
        for (int j = 0; j < DEB; j++) if (pend[i][j] == mLvl[i]) allDiff = 1'b0;
        if (allDiff) begin
          mLvl[i]  = s;
          mRise[i] = s;
          mFall[i] = ~s;
          pend[i].delete();
          if (i >= NUM_BTN) anySw = 1'b1;
        end
      end
    end
    swFlipPrev = anySw;
  endtask

  task automatic checkOutput();
    logic [20:0] lv, rs, fl;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      lv[i] = mLvl[i];
      rs[i] = mRise[i];
      fl[i] = mFall[i];
    end
    checkVal("btn",         32'(btn),         32'(lv[4:0]));
    checkVal("btn_press",   32'(btn_press),   32'(rs[4:0]));
    checkVal("btn_release", 32'(btn_release), 32'(fl[4:0]));
    checkVal("sw",          32'(sw),          32'(lv[20:5]));
    checkVal("sw_change",   32'(sw_change),   32'(mSwChg));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) modelEdge();
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    int pressCnt, relCnt, chgCnt, riseStep, relStep, sw0Step, sw15Step;
    logic [4:0]  bv;
    logic [15:0] sv;

    // Reset with BTNC and all switches already high.
    rst_n = 1'b0;
    applyStimulus(5'b00001, 16'hFFFF);
    modelReset();
    #1 checkOutput();
    step();
    step();
    rst_n = 1'b1;
    pressCnt = 0;
    chgCnt   = 0;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (btn_press[BTN_C]) pressCnt++;
      if (sw_change) chgCnt++;
    end
    checkVal("rst_btnc_level", 32'(btn[BTN_C]), 32'd1);
    checkVal("rst_btnc_press_count", 32'(pressCnt), 32'd1);
    checkVal("rst_sw_level", 32'(sw), 32'hFFFF);
    checkVal("rst_sw_change_count", 32'(chgCnt), 32'd1);

    // Clean press on BTNU.
    applyStimulus(5'b00011, 16'hFFFF);
    riseStep = 0;
    pressCnt = 0;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (btn[BTN_U] && riseStep == 0) riseStep = n;
      if (btn_press[BTN_U]) pressCnt++;
    end
    checkVal("press_latency", 32'(riseStep), 32'd6);
    checkVal("press_count", 32'(pressCnt), 32'd1);

    // Bouncy BTNL never settles long enough.
    applyStimulus(5'b00111, 16'hFFFF);
    repeat (3) step();
    applyStimulus(5'b00011, 16'hFFFF);
    step();
    applyStimulus(5'b00111, 16'hFFFF);
    repeat (3) step();
    applyStimulus(5'b00011, 16'hFFFF);
    pressCnt = 0;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (btn_press[BTN_L] || btn[BTN_L]) pressCnt++;
    end
    checkVal("bounce_activity", 32'(pressCnt), 32'd0);

    // BTNR held, then dropped.
    applyStimulus(5'b01011, 16'hFFFF);
    repeat (8) step();
    applyStimulus(5'b00011, 16'hFFFF);
    relStep = 0;
    relCnt  = 0;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (btn_release[BTN_R]) begin
        relCnt++;
        if (relStep == 0) relStep = n;
      end
    end
    checkVal("release_latency", 32'(relStep), 32'd6);
    checkVal("release_count", 32'(relCnt), 32'd1);
    checkVal("release_level", 32'(btn[BTN_R]), 32'd0);

    // SW[0] and SW[15] drop together.
    applyStimulus(5'b00011, 16'h7FFE);
    sw0Step  = 0;
    sw15Step = 0;
    chgCnt   = 0;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (!sw[0] && sw0Step == 0) sw0Step = n;
      if (!sw[15] && sw15Step == 0) sw15Step = n;
      if (sw_change) chgCnt++;
    end
    checkVal("simul_sw0_latency", 32'(sw0Step), 32'd6);
    checkVal("simul_same_edge", 32'(sw15Step), 32'(sw0Step));
    checkVal("simul_sw_change_count", 32'(chgCnt), 32'd1);
    checkVal("simul_sw_level", 32'(sw), 32'h7FFE);

    // Reset pulse while BTND is mid-debounce.
    applyStimulus(5'b10011, 16'h7FFE);
    repeat (4) step();
    checkVal("midrst_btnd_pending", 32'(btn[BTN_D]), 32'd0);
    rst_n = 1'b0;
    modelReset();
    #1 checkOutput();
    step();
    rst_n = 1'b1;
    riseStep = 0;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (btn[BTN_D] && riseStep == 0) riseStep = n;
    end
    checkVal("midrst_relatency", 32'(riseStep), 32'd6);

    // Random toggling with mixed bounce lengths.
    bv = 5'b10011;
    sv = 16'h7FFE;
    for (int n = 0; n < 400; n++) begin
      for (int b = 0; b < NUM_BTN; b++)
        if ($urandom_range(0, 5) == 0) bv[b] = ~bv[b];
      if ($urandom_range(0, 7) == 0) sv[$urandom_range(0, 15)] ^= 1'b1;
      if ($urandom_range(0, 19) == 0) sv ^= 16'($urandom);
      applyStimulus(bv, sv);
      repeat ($urandom_range(1, 8)) step();
    end
    repeat (12) step();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
